// File: rtl/bp_fe_pkg.sv
// Shared constants for the front-end branch-predictor update path.
// Update record layout is {correct (MSB), idx}; its width is idx width + 1.
package bp_fe_pkg;

  localparam int unsigned bp_fe_default_els_lp = 4;

  function automatic int unsigned bp_fe_upd_rec_width(input int unsigned idx_width);
    return idx_width + 1;
  endfunction

endpackage

// File: rtl/bp_fe_bp_update_if.sv
// Backend-to-frontend branch-resolution update channel (valid/ready).
interface bp_fe_bp_update_if #(
  parameter bht_idx_width_p = "inv"
);
  localparam int unsigned idx_w_lp = bht_idx_width_p;

  logic                upd_v_i;
  logic [idx_w_lp-1:0] upd_idx_i;
  logic                upd_correct_i;
  logic                upd_ready_o;

  modport master (output upd_v_i, upd_idx_i, upd_correct_i, input upd_ready_o);
  modport slave  (input upd_v_i, upd_idx_i, upd_correct_i, output upd_ready_o);
endinterface

// File: rtl/bp_fe_bp_update_fifo.sv
// Circular update queue: storage, head/tail pointers and occupancy count.
// Supports an in-place rewrite of the youngest entry's correct bit.
module bp_fe_bp_update_fifo
  import bp_fe_pkg::*;
#(
  parameter int unsigned width_p = 2,
  parameter int unsigned els_p   = bp_fe_default_els_lp
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             clr_i,
  input  logic                             enq_v_i,
  input  logic [width_p-1:0]               enq_data_i,
  input  logic                             deq_v_i,
  input  logic                             merge_v_i,
  input  logic                             merge_correct_i,
  output logic [width_p-1:0]               head_o,
  output logic [width_p-2:0]               youngest_idx_o,
  output logic [$clog2(els_p+1)-1:0]       count_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] head_r, tail_r, youngest_ptr;
  logic [cnt_w_lp-1:0] count_r;

  assign youngest_ptr   = tail_r - ptr_w_lp'(1);
  assign head_o         = mem[head_r];
  assign youngest_idx_o = mem[youngest_ptr][width_p-2:0];
  assign count_o        = count_r;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq_v_i) tail_r <= tail_r + ptr_w_lp'(1);
      if (deq_v_i) head_r <= head_r + ptr_w_lp'(1);
      count_r <= count_r + cnt_w_lp'(enq_v_i) - cnt_w_lp'(deq_v_i);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (enq_v_i) begin
      mem[tail_r] <= enq_data_i;
    end else if (merge_v_i) begin
      mem[youngest_ptr][width_p-1] <= merge_correct_i;
    end
  end

endmodule

// File: rtl/bp_fe_bp_update.sv
// Queues branch-resolution updates and drains them into the predictor write port,
// yielding to same-index predictor reads. Optional BP_FE_BP_UPDATE_COALESCE_EN merges repeats.
module bp_fe_bp_update
  import bp_fe_pkg::*;
#(
  parameter bht_idx_width_p = "inv",
  parameter int unsigned els_p = bp_fe_default_els_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bp_fe_bp_update_if.slave            upd,
  input  logic                        flush_i,
  input  logic                        r_v_i,
  input  logic [bht_idx_width_p-1:0]  idx_r_i,
  output logic                        w_v_o,
  output logic [bht_idx_width_p-1:0]  idx_w_o,
  output logic                        correct_o,
  output logic [$clog2(els_p+1)-1:0]  count_o
);

  localparam int unsigned idx_w_lp = bht_idx_width_p;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  localparam int unsigned rec_w_lp = bp_fe_upd_rec_width(idx_w_lp);
`ifdef BP_FE_BP_UPDATE_COALESCE_EN
  localparam bit coalesce_lp = 1'b1;
`else
  localparam bit coalesce_lp = 1'b0;
`endif

  typedef struct packed {
    logic                correct;
    logic [idx_w_lp-1:0] idx;
  } upd_rec_t;

  upd_rec_t            head, enq_rec;
  logic [idx_w_lp-1:0] youngest_idx;
  logic [cnt_w_lp-1:0] count;
  logic                empty, ready, accept, deq, tail_hit, merge_v, enq_v;

  assign empty   = (count == '0);
  assign ready   = !reset_i && (count != cnt_w_lp'(els_p));
  assign accept  = upd.upd_v_i && ready;
  assign enq_rec = '{correct: upd.upd_correct_i, idx: upd.upd_idx_i};

  // A predictor read of the head index always wins; the write simply waits.
  assign w_v_o = !reset_i && !empty && !(r_v_i && (idx_r_i == head.idx));
  assign deq   = w_v_o && !flush_i;

  // Youngest entry is mergeable only if it is not the head leaving this cycle.
  assign tail_hit = !empty && (youngest_idx == upd.upd_idx_i)
                    && !(deq && (count == cnt_w_lp'(1)));
  assign merge_v  = coalesce_lp && accept && !flush_i && tail_hit;
  assign enq_v    = accept && !flush_i && !merge_v;

  assign upd.upd_ready_o = ready;
  assign idx_w_o         = head.idx;
  assign correct_o       = head.correct;
  assign count_o         = count;

  bp_fe_bp_update_fifo #(
    .width_p (rec_w_lp),
    .els_p   (els_p)
  ) fifo (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .clr_i           (flush_i),
    .enq_v_i         (enq_v),
    .enq_data_i      (enq_rec),
    .deq_v_i         (deq),
    .merge_v_i       (merge_v),
    .merge_correct_i (upd.upd_correct_i),
    .head_o          (head),
    .youngest_idx_o  (youngest_idx),
    .count_o         (count)
  );

endmodule

// File: tb/tb_bp_fe_bp_update.sv
// Directed self-checking bench for bp_fe_bp_update (els_p=4, 4-bit index).
module tb_bp_fe_bp_update;

  localparam int unsigned idx_w = 4;
  localparam int unsigned els   = 4;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             flush_i;
  logic             r_v_i;
  logic [idx_w-1:0] idx_r_i;
  logic             w_v_o;
  logic [idx_w-1:0] idx_w_o;
  logic             correct_o;
  logic [2:0]       count_o;

  int n_assert = 0;
  int n_fail   = 0;

  bp_fe_bp_update_if #(.bht_idx_width_p(idx_w)) upd_if ();

  bp_fe_bp_update #(.bht_idx_width_p(idx_w), .els_p(els)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .upd       (upd_if),
    .flush_i   (flush_i),
    .r_v_i     (r_v_i),
    .idx_r_i   (idx_r_i),
    .w_v_o     (w_v_o),
    .idx_w_o   (idx_w_o),
    .correct_o (correct_o),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [idx_w-1:0] idx, input logic c);
    upd_if.upd_v_i       = v;
    upd_if.upd_idx_i     = idx;
    upd_if.upd_correct_i = c;
  endtask

  initial begin
    reset_i = 1'b1;
    flush_i = 1'b0;
    r_v_i   = 1'b0;
    idx_r_i = '0;
    drive_upd(1'b0, '0, 1'b0);
    tick();
    tick();
    chk("rst_count", 32'(count_o), 0);
    chk("rst_ready", 32'(upd_if.upd_ready_o), 0);
    chk("rst_wv", 32'(w_v_o), 0);

    // Single update, one-cycle latency
    reset_i = 1'b0;
    settle();
    chk("post_rst_ready", 32'(upd_if.upd_ready_o), 1);
    chk("post_rst_wv", 32'(w_v_o), 0);
    drive_upd(1'b1, 4'd5, 1'b1);
    settle();
    chk("no_bypass_wv", 32'(w_v_o), 0);
    tick();
    drive_upd(1'b0, '0, 1'b0);
    settle();
    chk("single_wv", 32'(w_v_o), 1);
    chk("single_idx", 32'(idx_w_o), 5);
    chk("single_corr", 32'(correct_o), 1);
    chk("single_count", 32'(count_o), 1);
    tick();
    chk("single_drained", 32'(count_o), 0);
    chk("single_wv_after", 32'(w_v_o), 0);

    // Fill to full while the head collides with a read
    r_v_i   = 1'b1;
    idx_r_i = 4'd1;
    for (int i = 1; i <= 4; i++) begin
      drive_upd(1'b1, 4'(i), 1'(i % 2));
      tick();
      chk($sformatf("fill_count%0d", i), 32'(count_o), 32'(i));
    end
    drive_upd(1'b1, 4'd5, 1'b1);
    settle();
    chk("full_ready", 32'(upd_if.upd_ready_o), 0);
    chk("full_stall_wv", 32'(w_v_o), 0);
    tick();
    chk("full_held_count", 32'(count_o), 4);
    r_v_i = 1'b0;
    settle();
    chk("full_pop_wv", 32'(w_v_o), 1);
    chk("full_pop_idx", 32'(idx_w_o), 1);
    chk("full_pop_ready", 32'(upd_if.upd_ready_o), 0);
    tick();
    chk("full_pop_no_accept", 32'(count_o), 3);
    chk("order_idx2", 32'(idx_w_o), 2);
    chk("order_corr2", 32'(correct_o), 0);
    chk("ready_after_pop", 32'(upd_if.upd_ready_o), 1);
    tick();
    drive_upd(1'b0, '0, 1'b0);
    chk("enq_deq_count", 32'(count_o), 3);
    settle();
    chk("order_idx3", 32'(idx_w_o), 3);
    chk("order_corr3", 32'(correct_o), 1);
    tick();
    chk("order_idx4", 32'(idx_w_o), 4);
    tick();
    chk("order_idx5", 32'(idx_w_o), 5);
    chk("order_corr5", 32'(correct_o), 1);
    tick();
    chk("order_empty", 32'(count_o), 0);

    // Two-cycle read collision on head idx 3
    drive_upd(1'b1, 4'd3, 1'b0);
    tick();
    drive_upd(1'b0, '0, 1'b0);
    r_v_i   = 1'b1;
    idx_r_i = 4'd3;
    settle();
    chk("coll_c1_wv", 32'(w_v_o), 0);
    tick();
    chk("coll_c2_wv", 32'(w_v_o), 0);
    chk("coll_c2_count", 32'(count_o), 1);
    tick();
    idx_r_i = 4'd2;
    settle();
    chk("coll_clear_wv", 32'(w_v_o), 1);
    chk("coll_clear_idx", 32'(idx_w_o), 3);
    tick();
    chk("coll_popped", 32'(count_o), 0);

    // Flush with a same-cycle update
    r_v_i   = 1'b1;
    idx_r_i = 4'ha;
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b1, 4'(4'ha + i), 1'b0);
      tick();
    end
    chk("pre_flush_count", 32'(count_o), 3);
    drive_upd(1'b1, 4'hd, 1'b1);
    flush_i = 1'b1;
    r_v_i   = 1'b0;
    settle();
    chk("flush_cycle_wv", 32'(w_v_o), 1);
    chk("flush_cycle_idx", 32'(idx_w_o), 32'h0a);
    tick();
    flush_i = 1'b0;
    drive_upd(1'b0, '0, 1'b0);
    settle();
    chk("flush_count", 32'(count_o), 0);
    chk("flush_wv", 32'(w_v_o), 0);

    // Repeated index while the queue is held
    r_v_i   = 1'b1;
    idx_r_i = 4'd7;
    drive_upd(1'b1, 4'd7, 1'b0);
    tick();
    drive_upd(1'b1, 4'd7, 1'b1);
    tick();
    drive_upd(1'b0, '0, 1'b0);
`ifdef BP_FE_BP_UPDATE_COALESCE_EN
    chk("coal_count", 32'(count_o), 1);
    r_v_i = 1'b0;
    settle();
    chk("coal_idx", 32'(idx_w_o), 7);
    chk("coal_corr", 32'(correct_o), 1);
    tick();
`else
    chk("nocoal_count", 32'(count_o), 2);
    r_v_i = 1'b0;
    settle();
    chk("nocoal_idx0", 32'(idx_w_o), 7);
    chk("nocoal_corr0", 32'(correct_o), 0);
    tick();
    chk("nocoal_corr1", 32'(correct_o), 1);
    tick();
`endif
    chk("dup_drained", 32'(count_o), 0);

    // Reset asserted mid-operation
    r_v_i   = 1'b1;
    idx_r_i = 4'd9;
    drive_upd(1'b1, 4'd9, 1'b1);
    tick();
    drive_upd(1'b1, 4'd8, 1'b0);
    tick();
    drive_upd(1'b0, '0, 1'b0);
    chk("mid_pre_count", 32'(count_o), 2);
    reset_i = 1'b1;
    r_v_i   = 1'b0;
    settle();
    chk("mid_rst_ready", 32'(upd_if.upd_ready_o), 0);
    chk("mid_rst_wv", 32'(w_v_o), 0);
    tick();
    chk("mid_rst_count", 32'(count_o), 0);
    reset_i = 1'b0;
    settle();
    chk("mid_rel_ready", 32'(upd_if.upd_ready_o), 1);
    chk("mid_rel_wv", 32'(w_v_o), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
